tlv_stream_decoder: RTL and testbench

TLV_STREAM_DECODER -- requirements
Module: tlv_stream_decoder

---
 rtl/tlv_pkg.sv | 47 ++++
 rtl/tlv_hdr_parse.sv | 53 +++++
 rtl/tlv_stream_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_tlv_stream_decoder.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlv_pkg.sv
// Shared definitions for the TLV stream decoder: byte prefixes, FSM states,
// register offsets, error codes and the result record layout.
package tlv_pkg;

    localparam logic [7:0] PFX_FD = 8'hFD;
    localparam logic [7:0] PFX_FE = 8'hFE;
    localparam logic [7:0] PFX_FF = 8'hFF;

    // Widest header: 5-byte type field plus 9-byte length field.
    localparam int         WIN_BYTES = 14;
    localparam logic [3:0] VOFF_MAX  = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_EMIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [2:0] REG_START_OFF = 3'd0;
    localparam logic [2:0] REG_TOTAL_LEN = 3'd1;
    localparam logic [2:0] REG_CMD       = 3'd2;
    localparam logic [2:0] REG_STATUS    = 3'd3;
    localparam logic [2:0] REG_RES_TYPE  = 3'd4;
    localparam logic [2:0] REG_RES_LEN   = 3'd5;
    localparam logic [2:0] REG_RES_VOFF  = 3'd6;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_HDR_TRUNC   = 2'd1,
        ERR_VAL_OVERRUN = 2'd2
    } err_t;

    typedef struct packed {
        logic [31:0] rec_type;
        logic [63:0] rec_len;
        logic [3:0]  voff;
    } rec_t;

    function automatic logic [3:0] value_offset(input logic [3:0] tw, input logic [3:0] lw);
        logic [4:0] sum;
        sum = {1'b0, tw} + {1'b0, lw};
        return (sum > {1'b0, VOFF_MAX}) ? VOFF_MAX : sum[3:0];
    endfunction

endpackage

// File: rtl/tlv_hdr_parse.sv
// Combinational TLV header parser over a 14-byte window (byte 0 in the MSBs):
// returns the type and length values and the byte widths of both fields.
module tlv_hdr_parse
    import tlv_pkg::*;
(
    input  logic [WIN_BYTES*8-1:0] window,
    output logic [31:0]            rec_type,
    output logic [63:0]            rec_len,
    output logic [3:0]             type_width,
    output logic [3:0]             len_width
);

    logic [7:0] b [WIN_BYTES];
    logic [7:0] la [9];

    for (genvar gi = 0; gi < WIN_BYTES; gi++) begin : g_bytes
        assign b[gi] = window[(WIN_BYTES-1-gi)*8 +: 8];
    end

    always_comb begin
        rec_type   = {24'h0, b[0]};
        type_width = 4'd1;
        if (b[0] == PFX_FE) begin
            rec_type   = {b[1], b[2], b[3], b[4]};
            type_width = 4'd5;
        end else if (b[0] == PFX_FD) begin
            rec_type   = {16'h0, b[1], b[2]};
            type_width = 4'd3;
        end
    end

    // Length field starts right after the type field, at byte 1, 3 or 5.
    for (genvar gi = 0; gi < 9; gi++) begin : g_len_bytes
        assign la[gi] = (type_width == 4'd5) ? b[5+gi] :
                        (type_width == 4'd3) ? b[3+gi] : b[1+gi];
    end

    always_comb begin
        rec_len   = {56'h0, la[0]};
        len_width = 4'd1;
        if (la[0] == PFX_FF) begin
            rec_len   = {la[1], la[2], la[3], la[4], la[5], la[6], la[7], la[8]};
            len_width = 4'd9;
        end else if (la[0] == PFX_FE) begin
            rec_len   = {32'h0, la[1], la[2], la[3], la[4]};
            len_width = 4'd5;
        end else if (la[0] == PFX_FD) begin
            rec_len   = {48'h0, la[1], la[2]};
            len_width = 4'd3;
        end
    end

endmodule

// File: rtl/tlv_stream_decoder.sv
// CPU-mapped TLV record walker: the CPU fills a byte buffer, sets the region
// and issues go; each parsed record lands in a result FIFO the CPU drains.
module tlv_stream_decoder
    import tlv_pkg::*;
#(
    parameter int BUF_WORDS  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] cpu_din,
    input  logic [63:0] cpu_ain,
    input  logic        cpu_wren,
    output logic [63:0] cpu_dout
);

    localparam int BUF_BYTES = 8 * BUF_WORDS;
    localparam int BIDX_W    = $clog2(BUF_BYTES);
    localparam int WSEL_W    = $clog2(BUF_WORDS);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;

    state_t      state_reg, state_next;
    err_t        err_reg, err_next;
    logic [65:0] cur_reg, cur_next;
    logic [63:0] start_off_reg, total_len_reg;
    logic [15:0] rec_count_reg;
    rec_t        hdr_reg;
    logic        hdr_load, push, pop, flush, count_clear;

    logic        is_reg, busy, cfg_we, cmd_wr, go_cmd, abort_cmd;
    logic [3:0]  word_sel;
    logic [2:0]  reg_sel;
    logic [63:0] rd_data;
    logic        unused_ain;

    assign is_reg     = cpu_ain[4];
    assign word_sel   = cpu_ain[3:0];
    assign reg_sel    = cpu_ain[2:0];
    assign unused_ain = ^cpu_ain[63:5];
    assign busy       = (state_reg == ST_HDR) || (state_reg == ST_EMIT);
    assign cfg_we     = cpu_wren && !busy;
    assign cmd_wr     = cpu_wren && is_reg && (reg_sel == REG_CMD);
    assign go_cmd     = cmd_wr && cpu_din[0];
    assign abort_cmd  = cmd_wr && cpu_din[1];

    // Record buffer, also viewed as big-endian bytes for the header window.
    logic [63:0] buf_mem   [BUF_WORDS];
    logic [7:0]  buf_bytes [BUF_BYTES];

    for (genvar gi = 0; gi < BUF_WORDS; gi++) begin : g_buf
        logic [63:0] word_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                word_reg <= '0;
            else if (cfg_we && !is_reg && word_sel == 4'(gi))
                word_reg <= cpu_din;
        end
        assign buf_mem[gi] = word_reg;
        for (genvar gj = 0; gj < 8; gj++) begin : g_byte
            assign buf_bytes[gi*8+gj] = word_reg[63-8*gj -: 8];
        end
    end

    logic [WIN_BYTES*8-1:0] window;
    for (genvar gi = 0; gi < WIN_BYTES; gi++) begin : g_win
        logic [65:0] idx;
        assign idx = cur_reg + 66'(gi);
        assign window[(WIN_BYTES-1-gi)*8 +: 8] =
            (idx < 66'(BUF_BYTES)) ? buf_bytes[idx[BIDX_W-1:0]] : 8'h00;
    end

    logic [31:0] parse_type;
    logic [63:0] parse_len;
    logic [3:0]  parse_tw, parse_lw, parse_voff;

    tlv_hdr_parse u_parse (
        .window     (window),
        .rec_type   (parse_type),
        .rec_len    (parse_len),
        .type_width (parse_tw),
        .len_width  (parse_lw)
    );

    assign parse_voff = value_offset(parse_tw, parse_lw);

    logic [65:0] end_sum, end_pos;
    assign end_sum = {2'b0, start_off_reg} + {2'b0, total_len_reg};
    assign end_pos = (end_sum > 66'(BUF_BYTES)) ? 66'(BUF_BYTES) : end_sum;

    // Result FIFO
    rec_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   fifo_count_reg;
    logic             fifo_empty, fifo_full;
    rec_t             head;

    assign fifo_empty = (fifo_count_reg == '0);
    assign fifo_full  = (fifo_count_reg == (PTR_W+1)'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr_reg];
    assign pop        = !cpu_wren && is_reg && (reg_sel == REG_RES_VOFF) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= hdr_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + CNT_ONE;
                2'b01:   fifo_count_reg <= fifo_count_reg - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cur_reg   <= '0;
            err_reg   <= ERR_NONE;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cur_next    = cur_reg;
        err_next    = err_reg;
        hdr_load    = 1'b0;
        push        = 1'b0;
        flush       = 1'b0;
        count_clear = 1'b0;
        if (abort_cmd) begin
            state_next  = ST_IDLE;
            err_next    = ERR_NONE;
            flush       = 1'b1;
            count_clear = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (go_cmd) begin
                        cur_next    = {2'b0, start_off_reg};
                        err_next    = ERR_NONE;
                        count_clear = 1'b1;
                        state_next  = (total_len_reg == '0) ? ST_DONE : ST_HDR;
                    end
                end
                ST_HDR: begin
                    hdr_load = 1'b1;
                    if (cur_reg + 66'(parse_voff) > end_pos) begin
                        state_next = ST_ERR;
                        err_next   = ERR_HDR_TRUNC;
                    end else begin
                        state_next = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    // A pop in the same cycle does not free a slot until the next one.
                    if (!fifo_full) begin
                        push     = 1'b1;
                        cur_next = cur_reg + 66'(hdr_reg.voff) + {2'b0, hdr_reg.rec_len};
                        if (cur_next == end_pos) begin
                            state_next = ST_DONE;
                        end else if (cur_next > end_pos) begin
                            state_next = ST_ERR;
                            err_next   = ERR_VAL_OVERRUN;
                        end else begin
                            state_next = ST_HDR;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (!is_reg) begin
            if ({1'b0, word_sel} < 5'(BUF_WORDS))
                rd_data = buf_mem[word_sel[WSEL_W-1:0]];
        end else begin
            case (reg_sel)
                REG_START_OFF: rd_data = start_off_reg;
                REG_TOTAL_LEN: rd_data = total_len_reg;
                REG_STATUS:    rd_data = {32'h0, rec_count_reg, 8'(fifo_count_reg), 1'b0,
                                          err_reg, fifo_full, fifo_empty, state_reg};
                REG_RES_TYPE:  rd_data = fifo_empty ? 64'h0 : {32'h0, head.rec_type};
                REG_RES_LEN:   rd_data = fifo_empty ? 64'h0 : head.rec_len;
                REG_RES_VOFF:  rd_data = fifo_empty ? 64'h0 : {60'h0, head.voff};
                default:       rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_off_reg <= '0;
            total_len_reg <= '0;
            rec_count_reg <= '0;
            hdr_reg       <= '0;
            cpu_dout      <= '0;
        end else begin
            if (cfg_we && is_reg && reg_sel == REG_START_OFF) start_off_reg <= cpu_din;
            if (cfg_we && is_reg && reg_sel == REG_TOTAL_LEN) total_len_reg <= cpu_din;
            if (hdr_load) hdr_reg <= '{rec_type: parse_type, rec_len: parse_len, voff: parse_voff};
            if (count_clear)
                rec_count_reg <= '0;
            else if (push && rec_count_reg != 16'hFFFF)
                rec_count_reg <= rec_count_reg + 16'd1;
            cpu_dout <= rd_data;
        end
    end

endmodule

// File: tb/tb_tlv_stream_decoder.sv
// Bench for tlv_stream_decoder: directed and random TLV walks checked against
// a byte-level reference walk of the buffer image.
module tb_tlv_stream_decoder;

    localparam int BW     = 4;
    localparam int FDEPTH = 2;
    localparam int NBYTES = 8 * BW;

    localparam logic [63:0] A_START  = 64'h10;
    localparam logic [63:0] A_TOTAL  = 64'h11;
    localparam logic [63:0] A_CMD    = 64'h12;
    localparam logic [63:0] A_STATUS = 64'h13;
    localparam logic [63:0] A_RTYPE  = 64'h14;
    localparam logic [63:0] A_RLEN   = 64'h15;
    localparam logic [63:0] A_RVOFF  = 64'h16;

    localparam int S_DONE = 3;
    localparam int S_ERR  = 4;

    typedef struct packed {
        logic [31:0] t;
        logic [63:0] l;
        logic [3:0]  v;
    } exp_rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] cpu_din, cpu_ain, cpu_dout;
    logic        cpu_wren;

    int vec_count = 0;
    int err_count = 0;

    logic [7:0] img [NBYTES];
    exp_rec_t   exp_q [$];
    int         exp_state, exp_err;

    always #5 clk = ~clk;

    tlv_stream_decoder #(.BUF_WORDS(BW), .FIFO_DEPTH(FDEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_din  (cpu_din),
        .cpu_ain  (cpu_ain),
        .cpu_wren (cpu_wren),
        .cpu_dout (cpu_dout)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [63:0] a, input logic [63:0] d);
        cpu_ain  = a;
        cpu_din  = d;
        cpu_wren = 1'b1;
        @(posedge clk); #1;
        cpu_wren = 1'b0;
        cpu_ain  = 64'h0;
    endtask

    task automatic cpu_read(input logic [63:0] a, output logic [63:0] d);
        cpu_ain  = a;
        cpu_wren = 1'b0;
        @(posedge clk); #1;
        d = cpu_dout;
        cpu_ain = 64'h0;
    endtask

    task automatic load_image();
        logic [63:0] w;
        for (int i = 0; i < BW; i++) begin
            w = '0;
            for (int k = 0; k < 8; k++) w = {w[55:0], img[8*i+k]};
            cpu_write(64'(i), w);
        end
    endtask

    function automatic logic [7:0] img_byte(input logic [65:0] i);
        if (i < 66'(NBYTES)) return img[i[4:0]];
        return 8'h00;
    endfunction

    function automatic logic [63:0] get_be(input logic [65:0] i, input int n);
        logic [63:0] v = '0;
        for (int k = 0; k < n; k++) v = {v[55:0], img_byte(i + 66'(k))};
        return v;
    endfunction

    // Walk the image record by record, straight from the TLV encoding rules.
    task automatic model_walk(input logic [63:0] start, input logic [63:0] total);
        logic [65:0] cur, endp, len;
        logic [7:0]  p;
        logic [31:0] t;
        int          tw, lw, voff;
        exp_rec_t    r;
        exp_q.delete();
        exp_err = 0;
        endp = {2'b0, start} + {2'b0, total};
        if (endp > 66'(NBYTES)) endp = 66'(NBYTES);
        if (total == 0) begin
            exp_state = S_DONE;
            return;
        end
        cur = {2'b0, start};
        forever begin
            p  = img_byte(cur);
            tw = (p == 8'hFE) ? 5 : (p == 8'hFD) ? 3 : 1;
            t  = (tw == 1) ? {24'h0, p} : 32'(get_be(cur + 66'(1), tw - 1));
            p  = img_byte(cur + 66'(tw));
            lw = (p == 8'hFF) ? 9 : (p == 8'hFE) ? 5 : (p == 8'hFD) ? 3 : 1;
            len = (lw == 1) ? 66'(p) : 66'(get_be(cur + 66'(tw + 1), lw - 1));
            voff = (tw + lw > 14) ? 14 : tw + lw;
            if (cur + 66'(voff) > endp) begin
                exp_state = S_ERR;
                exp_err   = 1;
                return;
            end
            r.t = t;
            r.l = len[63:0];
            r.v = 4'(voff);
            exp_q.push_back(r);
            cur = cur + 66'(voff) + len;
            if (cur == endp) begin
                exp_state = S_DONE;
                return;
            end
            if (cur > endp) begin
                exp_state = S_ERR;
                exp_err   = 2;
                return;
            end
        end
    endtask

    // Pop every result as it appears, then check the terminal STATUS word.
    task automatic drain(input string name);
        logic [63:0] st, d, exp_st;
        int          popped;
        bit          fin;
        popped = 0;
        fin    = 1'b0;
        st     = '0;
        for (int guard = 0; guard < 400 && !fin; guard++) begin
            cpu_read(A_STATUS, st);
            if (st[15:8] != 8'h0) begin
                if (popped < exp_q.size()) begin
                    cpu_read(A_RTYPE, d);
                    check_val("res_type", d, {32'h0, exp_q[popped].t});
                    cpu_read(A_RLEN, d);
                    check_val("res_len", d, exp_q[popped].l);
                    cpu_read(A_RVOFF, d);
                    check_val("res_voff", d, {60'h0, exp_q[popped].v});
                end else begin
                    cpu_read(A_RVOFF, d);
                end
                popped++;
            end else if (st[2:0] == 3'(S_DONE) || st[2:0] == 3'(S_ERR)) begin
                fin = 1'b1;
            end
        end
        check_val("walk_finished", 64'(fin), 64'd1);
        check_val("record_count", 64'(popped), 64'(exp_q.size()));
        exp_st = {32'h0, 16'(exp_q.size()), 8'h0, 1'b0, 2'(exp_err), 1'b0, 1'b1, 3'(exp_state)};
        check_val("final_status", st, exp_st);
        $display("walk %s: records=%0d state=%0d err=%0d", name, popped, st[2:0], st[6:5]);
    endtask

    task automatic run_walk(input string name, input logic [63:0] start, input logic [63:0] total);
        model_walk(start, total);
        cpu_write(A_START, start);
        cpu_write(A_TOTAL, total);
        cpu_write(A_CMD, 64'h1);
        drain(name);
    endtask

    task automatic clear_image();
        for (int i = 0; i < NBYTES; i++) img[i] = 8'h00;
    endtask

    task automatic five_small_records();
        clear_image();
        for (int i = 0; i < 5; i++) img[2*i] = 8'(i + 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  r8;
        rst      = 1'b1;
        cpu_wren = 1'b0;
        cpu_ain  = 64'h0;
        cpu_din  = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_dout", cpu_dout, 64'h0);
        rst = 1'b0;
        cpu_read(A_STATUS, d);
        check_val("reset_status", d, 64'h8);
        cpu_read(A_START, d);
        check_val("reset_start_off", d, 64'h0);
        cpu_read(64'h0, d);
        check_val("reset_buf0", d, 64'h0);

        // One record {1, 5, voff 2}
        clear_image();
        img[0] = 8'h01; img[1] = 8'h05;
        load_image();
        cpu_read(64'h0, d);
        check_val("buf0_readback", d, 64'h0105_0000_0000_0000);
        run_walk("single", 64'd0, 64'd7);

        // FE type, FD length: {0x100, 16, voff 8}
        clear_image();
        img[0] = 8'hFE; img[3] = 8'h01; img[5] = 8'hFD; img[7] = 8'h10;
        for (int i = 8; i < 24; i++) img[i] = 8'($urandom);
        load_image();
        run_walk("wide_hdr", 64'd0, 64'd24);

        // Three back-to-back records; first push lands 2 cycles after go
        clear_image();
        img[0] = 8'h01; img[2] = 8'h02; img[4] = 8'h03;
        load_image();
        model_walk(64'd0, 64'd6);
        cpu_write(A_START, 64'd0);
        cpu_write(A_TOTAL, 64'd6);
        cpu_write(A_CMD, 64'h1);
        cpu_read(A_STATUS, d);
        check_val("go_plus1_status", d, 64'h9);
        cpu_read(A_STATUS, d);
        check_val("go_plus2_status", d, 64'hA);
        cpu_read(A_STATUS, d);
        check_val("first_push_status", d, 64'h1_0101);
        drain("three");

        // FF length overruns the buffer: record still pushed, then value overrun
        for (int i = 0; i < NBYTES; i++) img[i] = 8'($urandom);
        img[0] = 8'h07; img[1] = 8'hFF;
        for (int i = 2; i < 9; i++) img[i] = 8'h00;
        img[9] = 8'hFF;
        load_image();
        run_walk("overrun", 64'd0, 64'd32);

        // Header truncated
        clear_image();
        img[0] = 8'hFE;
        load_image();
        run_walk("truncated", 64'd0, 64'd3);

        // Empty region completes immediately
        run_walk("empty", 64'd0, 64'd0);

        // FIFO fills and the walk stalls; config writes are ignored while busy
        five_small_records();
        load_image();
        model_walk(64'd0, 64'd10);
        cpu_write(A_START, 64'd0);
        cpu_write(A_TOTAL, 64'd10);
        cpu_write(A_CMD, 64'h1);
        repeat (12) cpu_read(A_STATUS, d);
        check_val("stalled_status", d, 64'h2_0212);
        cpu_write(A_START, 64'd5);
        cpu_read(A_START, d);
        check_val("busy_start_write_ignored", d, 64'd0);
        drain("backpressure");

        // Abort (with go) while in HDR
        cpu_write(A_CMD, 64'h1);
        cpu_read(A_STATUS, d);
        cpu_read(A_STATUS, d);
        cpu_write(A_CMD, 64'h3);
        cpu_read(A_STATUS, d);
        check_val("abort_status", d, 64'h8);
        cpu_read(A_RVOFF, d);
        check_val("empty_pop_value", d, 64'h0);
        cpu_read(A_STATUS, d);
        check_val("empty_pop_status", d, 64'h8);

        // Randomized walks
        for (int n = 0; n < 40; n++) begin
            logic [63:0] st_off, tot;
            for (int i = 0; i < NBYTES; i++) begin
                int r;
                r = int'($urandom_range(0, 15));
                if (r < 10)      r8 = 8'(r % 4);
                else if (r < 12) r8 = 8'hFD;
                else if (r < 14) r8 = 8'hFE;
                else if (r < 15) r8 = 8'hFF;
                else             r8 = 8'($urandom);
                img[i] = r8;
            end
            load_image();
            st_off = 64'($urandom_range(0, 4));
            tot    = 64'($urandom_range(0, 34));
            if ($urandom_range(0, 7) == 0) tot = 64'hFFFF_FFFF_FFFF_FFF0;
            cpu_write(A_START, st_off);
            cpu_read(A_START, d);
            check_val("start_readback", d, st_off);
            run_walk($sformatf("rand%0d", n), st_off, tot);
        end

        // Reset in the middle of a walk
        five_small_records();
        load_image();
        cpu_write(A_START, 64'd0);
        cpu_write(A_TOTAL, 64'd10);
        cpu_write(A_CMD, 64'h1);
        cpu_read(A_STATUS, d);
        cpu_read(A_STATUS, d);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_read(A_STATUS, d);
        check_val("midwalk_reset_status", d, 64'h8);
        cpu_read(A_TOTAL, d);
        check_val("midwalk_reset_total", d, 64'h0);
        cpu_read(64'h0, d);
        check_val("midwalk_reset_buf0", d, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
